modulus_counter_ctrl: RTL

- Sequencer and configuration front-end for a programmable-modulus up-counter.
- Accepts a configuration word (terminal value, prescale, one-shot/periodic mode) through a valid/ready handshake, then runs, pauses and stops the count on command.
- Emits terminal-count and completion pulses plus a saturating wrap tally.
- Sits between a control/CSR layer and timing consumers that need a counter period set at run time.

---
 rtl/modulus_counter_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/modulus_counter_ctrl.sv
// rtl/modulus_counter_ctrl.sv - programmable-modulus up-counter sequencer
// Config front-end plus IDLE/RUN/HOLD/DONE control; all outputs come from flops.
module modulus_counter_ctrl #(
  parameter int WIDTH   = 6,
  parameter int PRESC_W = 4,
  parameter int WRAPS_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_mod,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_periodic,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic               tc,
  output logic               done,
  output logic [WRAPS_W-1:0] wraps
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   Q_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PC_ONE    = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [WRAPS_W-1:0] WR_ONE    = {{(WRAPS_W-1){1'b0}}, 1'b1};
  localparam logic [WRAPS_W-1:0] WRAPS_MAX = '1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [PRESC_W-1:0]   pc_q, pc_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 periodic_q, periodic_d;
  logic [WRAPS_W-1:0]   wraps_q, wraps_d;
  logic                 tc_q, tc_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    pc_d       = pc_q;
    wraps_d    = wraps_q;
    mod_d      = mod_q;
    presc_d    = presc_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    done_d     = 1'b0;

    // ready_q is high exactly in IDLE, so a start in the same cycle runs on the new word
    if (cfg_valid && ready_q) begin
      mod_d      = cfg_mod;
      presc_d    = cfg_presc;
      periodic_d = cfg_periodic;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          q_d     = '0;
          pc_d    = '0;
          wraps_d = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          q_d     = '0;
          pc_d    = '0;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (pc_q == presc_q) begin
          pc_d = '0;
          if (q_q == mod_q) begin
            q_d  = '0;
            tc_d = 1'b1;
            if (wraps_q != WRAPS_MAX) begin
              wraps_d = wraps_q + WR_ONE;
            end
            if (!periodic_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            q_d = q_q + Q_ONE;
          end
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          q_d     = '0;
          pc_d    = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        q_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_RUN) || (state_d == S_HOLD);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      pc_q       <= '0;
      wraps_q    <= '0;
      mod_q      <= '1;
      presc_q    <= '0;
      periodic_q <= 1'b1;
      tc_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      pc_q       <= pc_d;
      wraps_q    <= wraps_d;
      mod_q      <= mod_d;
      presc_q    <= presc_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign q         = q_q;
  assign tc        = tc_q;
  assign done      = done_q;
  assign wraps     = wraps_q;

endmodule
